// File: rtl/light_pkg.sv
// Shared codes for the intersection phase scheduler:
// light colours, phase states, grant owners.
package light_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } light_e;

  typedef enum logic [2:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    AR1 = 3'd2,
    CG  = 3'd3,
    CY  = 3'd4,
    WK  = 3'd5,
    AR2 = 3'd6,
    BAD = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    G_NONE  = 2'd0,
    G_CNTRY = 2'd1,
    G_PED   = 2'd2
  } grant_e;

  // Round-robin owner choice at the end of highway yellow.
  function automatic grant_e pick_grant(
    input logic   x,
    input logic   pend,
    input grant_e last
  );
    grant_e g;
    g = G_NONE;
    if (x && pend)
      g = (last == G_CNTRY) ? G_PED : G_CNTRY;
    else if (x)
      g = G_CNTRY;
    else if (pend)
      g = G_PED;
    return g;
  endfunction

endpackage

// File: rtl/light_phase_scheduler_phase_timer.sv
// Phase duration counter: clears on clr, counts ticks, saturates.
// Ports: clock/clear, clr, tick, n -> cnt, done (tick & cnt==n-1).
module phase_timer #(
  parameter int TW = 8
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          clr,
  input  logic          tick,
  input  logic [TW-1:0] n,
  output logic [TW-1:0] cnt,
  output logic          done
);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clock or posedge clear) begin
    if (clear)
      r_cnt <= '0;
    else if (clr)
      r_cnt <= '0;
    else if (tick && (r_cnt != '1))
      r_cnt <= r_cnt + TW'(1);
  end

  assign cnt  = r_cnt;
  assign done = tick && (r_cnt == n - TW'(1));

endmodule

// File: rtl/light_phase_scheduler.sv
// Highway/country/pedestrian phase scheduler with emergency preempt.
// Ports: clock, clear, tick, x, ped_req, emg -> hwy, cntry, walk, ped_ack, phase.
module light_phase_scheduler
  import light_pkg::*;
#(
  parameter int TW        = 8,
  parameter int HWY_MIN   = 4,
  parameter int YEL       = 3,
  parameter int ALLRED    = 2,
  parameter int CNTRY_MIN = 2,
  parameter int CNTRY_MAX = 6,
  parameter int WALK      = 5
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       tick,
  input  logic       x,
  input  logic       ped_req,
  input  logic       emg,
  output logic [1:0] hwy,
  output logic [1:0] cntry,
  output logic       walk,
  output logic       ped_ack,
  output logic [2:0] phase
);

  state_e        r_state;
  state_e        w_next;
  grant_e        r_grant;
  grant_e        r_last;
  logic          r_pend;
  logic          r_ack;
  logic [TW-1:0] w_n;
  logic [TW-1:0] w_cnt;
  logic          w_done;
  logic          w_req;
  logic          w_chg;
  logic          w_enter_wk;

  assign w_req      = x | r_pend;
  assign w_chg      = (w_next != r_state);
  assign w_enter_wk = (w_next == WK) && (r_state != WK);

  // Terminal count for the timed exit of the current phase.
  always_comb begin
    w_n = TW'(1);
    unique case (r_state)
      HY, CY:   w_n = TW'(YEL);
      AR1, AR2: w_n = TW'(ALLRED);
      CG:       w_n = TW'(CNTRY_MAX);
      WK:       w_n = TW'(WALK);
      default:  w_n = TW'(1);
    endcase
  end

  phase_timer #(.TW(TW)) u_tmr (
    .clock (clock),
    .clear (clear),
    .clr   (w_chg),
    .tick  (tick),
    .n     (w_n),
    .cnt   (w_cnt),
    .done  (w_done)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear)
      r_state <= HG;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      HG:
        if (tick && (w_cnt >= TW'(HWY_MIN - 1))
            && w_req && !emg)
          w_next = HY;
      HY:
        if (w_done) w_next = AR1;
      AR1:
        if (w_done) begin
          if (emg)                    w_next = HG;
          else if (r_grant == G_CNTRY) w_next = CG;
          else if (r_grant == G_PED)   w_next = WK;
          else                         w_next = HG;
        end
      CG:
        if (emg || w_done
            || (tick && (w_cnt >= TW'(CNTRY_MIN - 1)) && !x))
          w_next = CY;
      CY:
        if (w_done) w_next = AR2;
      WK:
        if (emg || w_done) w_next = AR2;
      AR2:
        if (w_done) w_next = HG;
      default:
        w_next = HG;
    endcase
  end

  // Request bookkeeping: a new press on the WK-entry edge stays pending.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_pend  <= 1'b0;
      r_last  <= G_PED;
      r_grant <= G_CNTRY;
      r_ack   <= 1'b0;
    end else begin
      r_pend <= ped_req | (r_pend & ~w_enter_wk);
      r_ack  <= w_enter_wk;
      if ((r_state == HY) && (w_next == AR1))
        r_grant <= pick_grant(x, r_pend, r_last);
      if ((w_next == CG) && (r_state != CG))
        r_last <= G_CNTRY;
      else if (w_enter_wk)
        r_last <= G_PED;
    end
  end

  always_comb begin
    hwy     = RED;
    cntry   = RED;
    walk    = 1'b0;
    ped_ack = r_ack;
    phase   = r_state;
    unique case (r_state)
      HG:      hwy   = GREEN;
      HY:      hwy   = YELLOW;
      CG:      cntry = GREEN;
      CY:      cntry = YELLOW;
      WK:      walk  = 1'b1;
      default: hwy   = RED;
    endcase
  end

endmodule
